demux_stream_router: RTL and testbench

//  Parametrised 1-to-N_OUT registered stream demultiplexer.

---
 rtl/demux_stream_router.sv | 140 ++++++++++++++
 tb/tb_demux_stream_router.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_router.sv
// demux_stream_router: 1-to-N_OUT registered valid/ready stream demultiplexer.
// Each output channel owns a one-word register that can drain and reload on
// the same edge. Words whose in_sel has no matching channel are consumed,
// dropped, and flagged on sel_err for one cycle.
// Optional feature macro: DEMUX_BCAST_EN adds in_bcast, which loads one word
// into every channel at once when all channels can take it.
module demux_stream_router #(
  parameter int N_OUT  = 4,
  parameter int DATA_W = 8,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
`ifdef DEMUX_BCAST_EN
  input  logic                    in_bcast,
`endif
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    sel_err
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  logic [N_OUT-1:0] free;      // channel can take a word this cycle
  logic [N_OUT-1:0] sel_hit;   // one-hot decode of a legal in_sel
  logic [N_OUT-1:0] load;      // channel captures in_data at the next edge
  logic             sel_legal;
  logic             bcast;
  logic             accept;
  logic             uc_ready;
  logic             sel_err_reg;
  logic             sel_err_next;

`ifdef DEMUX_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // A power-of-two channel count decodes every in_sel value, so only the
  // other counts need the range check.
  generate
    if ((2 ** SEL_W) == N_OUT) begin : g_sel_full
      assign sel_legal = 1'b1;
    end else begin : g_sel_range
      localparam logic [SEL_W:0] N_OUT_L = (SEL_W+1)'(N_OUT);
      assign sel_legal = ({1'b0, in_sel} < N_OUT_L);
    end
  endgenerate

  // Per-channel select decode; out-of-range selects hit no channel.
  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_dec
      assign sel_hit[gi] = sel_legal && (in_sel == SEL_W'(gi));
    end
  endgenerate

  // Ready is combinational from out_ready and en, never from in_valid.
  // An illegal select is always ready so the word can be dropped.
  always_comb begin
    uc_ready = sel_legal ? |(sel_hit & free) : 1'b1;
    in_ready = en & (bcast ? &free : uc_ready);
  end

  // Accept decode: which channels load, and whether a drop is flagged.
  always_comb begin
    accept       = in_valid & in_ready;
    load         = {N_OUT{1'b0}};
    sel_err_next = 1'b0;
    if (accept) begin
      if (bcast) begin
        load = {N_OUT{1'b1}};
      end else begin
        load         = sel_hit;
        sel_err_next = ~sel_legal;
      end
    end
  end

  // Per-channel EMPTY/FULL controller with its one-word data register.
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_ch
      ch_state_t         state_reg;
      ch_state_t         state_next;
      logic [DATA_W-1:0] data_reg;
      logic [DATA_W-1:0] data_next;

      assign free[gi]      = (state_reg == EMPTY) | out_ready[gi];
      assign out_valid[gi] = (state_reg == FULL);
      assign out_data[gi*DATA_W +: DATA_W] = data_reg;

      // Next state: a load always wins, so drain+load stays FULL (no bubble).
      always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        case (state_reg)
          EMPTY: begin
            if (load[gi]) state_next = FULL;
          end
          FULL: begin
            if (load[gi])           state_next = FULL;
            else if (out_ready[gi]) state_next = EMPTY;
          end
          default: state_next = EMPTY;
        endcase
        if (load[gi]) data_next = in_data;
      end

      // Channel state and payload registers; reset discards any held word.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg <= EMPTY;
          data_reg  <= '0;
        end else begin
          state_reg <= state_next;
          data_reg  <= data_next;
        end
      end
    end
  endgenerate

  // One-cycle drop indication for an accepted out-of-range select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err_reg <= 1'b0;
    else        sel_err_reg <= sel_err_next;
  end

  assign sel_err = sel_err_reg;

endmodule

// File: tb/tb_demux_stream_router.sv
// Directed testbench for demux_stream_router.
// DUT a: N_OUT=4, DATA_W=8. DUT b: N_OUT=3, DATA_W=8 (illegal-select drop).
// Broadcast steps compile only when DEMUX_BCAST_EN is defined.
module tb_demux_stream_router;

  logic        clk = 1'b0;
  logic        rst_n;
  int          tests = 0;
  int          fails = 0;

  // DUT a signals
  logic        en, in_valid, in_ready, sel_err;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid, out_ready;
  logic [31:0] out_data;
`ifdef DEMUX_BCAST_EN
  logic        in_bcast;
`endif

  // DUT b signals
  logic        en3, in_valid3, in_ready3, sel_err3;
  logic [7:0]  in_data3;
  logic [1:0]  in_sel3;
  logic [2:0]  out_valid3, out_ready3;
  logic [23:0] out_data3;
`ifdef DEMUX_BCAST_EN
  logic        in_bcast3;
`endif

  always #5 clk = ~clk;

  demux_stream_router #(.N_OUT(4), .DATA_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel),
`ifdef DEMUX_BCAST_EN
    .in_bcast(in_bcast),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .sel_err(sel_err)
  );

  demux_stream_router #(.N_OUT(3), .DATA_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en3), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .in_sel(in_sel3),
`ifdef DEMUX_BCAST_EN
    .in_bcast(in_bcast3),
`endif
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3), .sel_err(sel_err3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_sel = 2'd0; out_ready = 4'h0;
    en3 = 1'b0; in_valid3 = 1'b0; in_data3 = 8'h00; in_sel3 = 2'd0; out_ready3 = 3'h0;
`ifdef DEMUX_BCAST_EN
    in_bcast = 1'b0; in_bcast3 = 1'b0;
`endif
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", out_data, 32'h0);
    check("rst_selerr", 32'(sel_err), 32'h0);
    rst_n = 1'b1;
    en = 1'b1; en3 = 1'b1;
    tick();

    // T2 unicast
    out_ready = 4'hF; in_valid = 1'b1; in_data = 8'hA5; in_sel = 2'd2;
    #1 check("t2_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    check("t2_valid", 32'(out_valid), 32'h4);
    check("t2_data", 32'(out_data[23:16]), 32'hA5);
    tick();
    check("t2_drained", 32'(out_valid), 32'h0);
    $display("[TB] T2 unicast done");

    // T3 back-pressure on ch1
    out_ready = 4'b1101; in_valid = 1'b1; in_data = 8'h11; in_sel = 2'd1;
    #1 check("t3_ready1", 32'(in_ready), 32'h1);
    tick();
    in_data = 8'h22;
    #1 check("t3_ready2", 32'(in_ready), 32'h0);
    check("t3_hold_valid", 32'(out_valid), 32'h2);
    check("t3_hold_data", 32'(out_data[15:8]), 32'h11);
    tick();
    check("t3_stable", 32'(out_data[15:8]), 32'h11);
    out_ready = 4'hF;
    #1 check("t3_ready3", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    check("t3_pass_valid", 32'(out_valid), 32'h2);
    check("t3_pass_data", 32'(out_data[15:8]), 32'h22);
    tick();
    check("t3_empty", 32'(out_valid), 32'h0);
    $display("[TB] T3 back-pressure done");

    // T4 parallel drain
    out_ready = 4'h0; in_valid = 1'b1; in_data = 8'h44; in_sel = 2'd0;
    tick();
    in_data = 8'h77; in_sel = 2'd3;
    tick();
    in_valid = 1'b0;
    check("t4_full", 32'(out_valid), 32'h9);
    out_ready = 4'b1001; in_valid = 1'b1; in_data = 8'h33; in_sel = 2'd0;
    #1 check("t4_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0; out_ready = 4'h0;
    check("t4_valid", 32'(out_valid), 32'h1);
    check("t4_data0", 32'(out_data[7:0]), 32'h33);
    out_ready = 4'hF;
    tick();
    $display("[TB] T4 parallel drain done");

    // T5 en gating
    out_ready = 4'h0; in_valid = 1'b1; in_data = 8'h55; in_sel = 2'd2;
    tick();
    en = 1'b0; in_data = 8'h66; in_sel = 2'd0;
    #1 check("t5_en_ready", 32'(in_ready), 32'h0);
    out_ready = 4'hF;
    tick();
    check("t5_en_drain", 32'(out_valid), 32'h0);
    en = 1'b1; in_valid = 1'b0;
    $display("[TB] T5 en gating done");

    // T5 illegal select on the 3-channel instance
    out_ready3 = 3'h0; in_valid3 = 1'b1; in_data3 = 8'h12; in_sel3 = 2'd1;
    tick();
    in_data3 = 8'hEE; in_sel3 = 2'd3;
    #1 check("t5_bad_ready", 32'(in_ready3), 32'h1);
    check("t5_pre_err", 32'(sel_err3), 32'h0);
    tick();
    in_valid3 = 1'b0;
    check("t5_err_hi", 32'(sel_err3), 32'h1);
    check("t5_bad_valid", 32'(out_valid3), 32'h2);
    check("t5_bad_data", out_data3 & 32'hFFFFFF, 32'h001200);
    tick();
    check("t5_err_lo", 32'(sel_err3), 32'h0);
    check("t5_bad_valid2", 32'(out_valid3), 32'h2);
    $display("[TB] T5 illegal select done");

`ifdef DEMUX_BCAST_EN
    // T6 broadcast
    out_ready = 4'h0; in_valid = 1'b1; in_data = 8'h01; in_sel = 2'd1;
    tick();
    in_bcast = 1'b1; in_data = 8'h5A; in_sel = 2'd3;
    #1 check("t6_blocked", 32'(in_ready), 32'h0);
    out_ready = 4'b0010;
    #1 check("t6_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'h0;
    check("t6_valid", 32'(out_valid), 32'hF);
    check("t6_data", out_data, 32'h5A5A5A5A);
    check("t6_selerr", 32'(sel_err), 32'h0);
    $display("[TB] T6 broadcast done");
`endif

    // T1 asynchronous reset mid-stream with ch2 full
    out_ready = 4'h0; in_valid = 1'b1; in_data = 8'h99; in_sel = 2'd2;
    tick();
    in_valid = 1'b0;
    check("t1_pre", 32'(out_valid[2]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_valid", 32'(out_valid), 32'h0);
    check("t1_data", out_data, 32'h0);
    check("t1_selerr", 32'(sel_err), 32'h0);
    check("t1_valid_b", 32'(out_valid3), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t1_after", 32'(out_valid), 32'h0);
    $display("[TB] T1 reset done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
